// File: rtl/adder_acc_sequencer.sv
// adder_acc_sequencer: feeds a job's operand stream through the shared 32-bit / two-lane adder and returns the sum.
// Build option: define ADD_ACC_SEQ_SAT_EN to saturate words/lanes on overflow instead of wrapping.
module adder_acc_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_3_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [31:0]      init_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      op_data_i,
  output logic [31:0]      add_a_o,
  output logic [31:0]      add_b_o,
  output logic             add_mode_3_o,
  input  logic [31:0]      add_res_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam logic [31:0] LANE_MASK = 32'h003F_F3FF;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      acc_reg, acc_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             ovf_reg, ovf_next;
  logic             mode_3_reg, mode_3_next;

  logic [1:0]  lane_ovf;
  logic [9:0]  lane_val [2];
  logic        word_ovf;
  logic [31:0] word_val;
  logic [31:0] sum_word;
  logic        beat_ovf;

  // Lane k of the adder result sits at [16k+10:16k]; bit 16k+10 is the true sign.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      localparam int RB = 16 * gi;
      assign lane_ovf[gi] = add_res_i[RB+10] ^ add_res_i[RB+9];
`ifdef ADD_ACC_SEQ_SAT_EN
      assign lane_val[gi] = !lane_ovf[gi] ? add_res_i[RB+9:RB]
                          : (add_res_i[RB+10] ? 10'h200 : 10'h1FF);
`else
      assign lane_val[gi] = add_res_i[RB+9:RB];
`endif
    end
  endgenerate

  assign word_ovf = (acc_reg[31] == op_data_i[31]) && (add_res_i[31] != acc_reg[31]);
`ifdef ADD_ACC_SEQ_SAT_EN
  assign word_val = !word_ovf ? add_res_i
                  : (acc_reg[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
`else
  assign word_val = add_res_i;
`endif

  // Lane-1 output [25:16] is folded back into the lane-1 input slot [21:12].
  assign sum_word = mode_3_reg ? {10'b0, lane_val[1], 2'b0, lane_val[0]} : word_val;
  assign beat_ovf = mode_3_reg ? (|lane_ovf) : word_ovf;

  assign add_a_o      = acc_reg;
  assign add_b_o      = op_data_i;
  assign add_mode_3_o = mode_3_reg;
  assign op_ready_o   = (state_reg == ACC);
  assign res_valid_o  = (state_reg == DONE);
  assign res_data_o   = acc_reg;
  assign ovf_o        = ovf_reg;
  assign busy_o       = (state_reg != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      remaining_reg <= '0;
      ovf_reg       <= 1'b0;
      mode_3_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      remaining_reg <= remaining_next;
      ovf_reg       <= ovf_next;
      mode_3_reg    <= mode_3_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    remaining_next = remaining_reg;
    ovf_next       = ovf_reg;
    mode_3_next    = mode_3_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          mode_3_next    = mode_3_i;
          remaining_next = len_i;
          ovf_next       = 1'b0;
          acc_next       = mode_3_i ? (init_i & LANE_MASK) : init_i;
          state_next     = (len_i != '0) ? ACC : DONE;
        end
      end
      ACC: begin
        if (op_valid_i) begin
          acc_next       = sum_word;
          remaining_next = remaining_reg - CNT_W'(1);
          ovf_next       = ovf_reg | beat_ovf;
          if (remaining_reg == CNT_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
